// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory arbiter slice.
// Holds the FSM state enum, burst geometry and address masks.
package mem_arb_pkg;

  localparam int          BURST_WORDS = 8;
  localparam int          MEM_LAT     = 4;
  localparam logic [15:0] LINE_MASK   = 16'hFFF0;
  localparam logic [15:0] WORD_STEP   = 16'd2;

  typedef enum logic [1:0] {
    S_IDLE,
    S_I_FILL,
    S_D_FILL,
    S_D_WRITE
  } state_e;

endpackage

// File: rtl/mem_burst_seq.sv
// Line-fill burst sequencer: issue/return counters, read address
// generation and last-word detect.
// Ports: i_active (fill in progress), i_base, i_mem_valid in;
//        o_issue_en, o_addr, o_ret_idx, o_last out.
module mem_burst_seq
  import mem_arb_pkg::*;
#(
  parameter int BW = BURST_WORDS
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_active,
  input  logic [15:0] i_base,
  input  logic        i_mem_valid,
  output logic        o_issue_en,
  output logic [15:0] o_addr,
  output logic [2:0]  o_ret_idx,
  output logic        o_last
);

  localparam logic [3:0] CNT_MAX  = 4'(BW);
  localparam logic [3:0] CNT_LAST = 4'(BW - 1);

  logic [3:0]  r_issue_cnt;
  logic [3:0]  r_ret_cnt;
  logic [15:0] w_off;

  // Counters sit at zero whenever no fill is running.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_issue_cnt <= '0;
      r_ret_cnt   <= '0;
    end else if (!i_active) begin
      r_issue_cnt <= '0;
      r_ret_cnt   <= '0;
    end else begin
      if (r_issue_cnt < CNT_MAX)
        r_issue_cnt <= r_issue_cnt + 4'd1;
      if (i_mem_valid && (r_ret_cnt < CNT_MAX))
        r_ret_cnt <= r_ret_cnt + 4'd1;
    end
  end

  assign w_off      = WORD_STEP * {12'd0, r_issue_cnt};
  assign o_issue_en = i_active && (r_issue_cnt < CNT_MAX);
  assign o_addr     = i_base + w_off;
  assign o_ret_idx  = r_ret_cnt[2:0];
  assign o_last     = i_active && i_mem_valid
                   && (r_ret_cnt == CNT_LAST);

endmodule

// File: rtl/mem_arbiter.sv
// Shared-memory arbiter: D side at fixed priority over I side,
// 8-word line fills or single D writes to a pipelined memory.
// Ports: i_* I-side fill, d_* D-side fill/write, mem_* memory.
module mem_arbiter
  import mem_arb_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_req,
  input  logic [15:0] i_addr,
  output logic        i_grant,
  output logic        i_data_valid,
  output logic [2:0]  i_word_idx,
  output logic [15:0] i_data,
  output logic        i_done,
  input  logic        d_req,
  input  logic        d_wr,
  input  logic [15:0] d_addr,
  input  logic [15:0] d_wdata,
  output logic        d_grant,
  output logic        d_data_valid,
  output logic [2:0]  d_word_idx,
  output logic [15:0] d_data,
  output logic        d_done,
  output logic        mem_en,
  output logic        mem_wr,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  input  logic        mem_valid
);

  state_e      r_state;
  logic [15:0] r_base;
  logic [15:0] r_wdata;
  logic        r_i_done;
  logic        r_d_done;

  logic        w_i_fill;
  logic        w_d_fill;
  logic        w_d_wr_st;
  logic        w_fill;
  logic        w_issue_en;
  logic [15:0] w_seq_addr;
  logic [2:0]  w_ret_idx;
  logic        w_last;
  logic        w_i_req;
  logic        w_d_req;
  logic        w_i_dv;
  logic        w_d_dv;

  assign w_i_fill  = (r_state == S_I_FILL);
  assign w_d_fill  = (r_state == S_D_FILL);
  assign w_d_wr_st = (r_state == S_D_WRITE);
  assign w_fill    = w_i_fill || w_d_fill;

  // A requester is blind during its own done cycle so a level
  // request still held from the finished burst does not re-win.
  assign w_i_req = i_req && !r_i_done;
  assign w_d_req = d_req && !r_d_done;

  mem_burst_seq u_seq (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_active    (w_fill),
    .i_base      (r_base),
    .i_mem_valid (mem_valid),
    .o_issue_en  (w_issue_en),
    .o_addr      (w_seq_addr),
    .o_ret_idx   (w_ret_idx),
    .o_last      (w_last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_base   <= '0;
      r_wdata  <= '0;
      r_i_done <= 1'b0;
      r_d_done <= 1'b0;
    end else begin
      r_i_done <= 1'b0;
      r_d_done <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (w_d_req) begin
            if (d_wr) begin
              r_state <= S_D_WRITE;
              r_base  <= d_addr;
              r_wdata <= d_wdata;
            end else begin
              r_state <= S_D_FILL;
              r_base  <= d_addr & LINE_MASK;
            end
          end else if (w_i_req) begin
            r_state <= S_I_FILL;
            r_base  <= i_addr & LINE_MASK;
          end
        end
        S_I_FILL: begin
          if (w_last) begin
            r_state  <= S_IDLE;
            r_i_done <= 1'b1;
          end
        end
        S_D_FILL: begin
          if (w_last) begin
            r_state  <= S_IDLE;
            r_d_done <= 1'b1;
          end
        end
        S_D_WRITE: begin
          r_state  <= S_IDLE;
          r_d_done <= 1'b1;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign w_i_dv = w_i_fill && mem_valid;
  assign w_d_dv = w_d_fill && mem_valid;

  assign i_grant      = w_i_fill;
  assign i_data_valid = w_i_dv;
  assign i_word_idx   = w_i_dv ? w_ret_idx : 3'd0;
  assign i_data       = w_i_dv ? mem_rdata : 16'd0;
  assign i_done       = r_i_done;

  assign d_grant      = w_d_fill || w_d_wr_st;
  assign d_data_valid = w_d_dv;
  assign d_word_idx   = w_d_dv ? w_ret_idx : 3'd0;
  assign d_data       = w_d_dv ? mem_rdata : 16'd0;
  assign d_done       = r_d_done;

  always_comb begin
    mem_en    = 1'b0;
    mem_wr    = 1'b0;
    mem_addr  = 16'd0;
    mem_wdata = 16'd0;
    unique case (1'b1)
      w_d_wr_st: begin
        mem_en    = 1'b1;
        mem_wr    = 1'b1;
        mem_addr  = r_base;
        mem_wdata = r_wdata;
      end
      (w_fill && w_issue_en): begin
        mem_en   = 1'b1;
        mem_addr = w_seq_addr;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter with a pipelined memory
// model and a scoreboard of expected returned words.
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        i_req;
  logic [15:0] i_addr;
  logic        i_grant;
  logic        i_data_valid;
  logic [2:0]  i_word_idx;
  logic [15:0] i_data;
  logic        i_done;
  logic        d_req;
  logic        d_wr;
  logic [15:0] d_addr;
  logic [15:0] d_wdata;
  logic        d_grant;
  logic        d_data_valid;
  logic [2:0]  d_word_idx;
  logic [15:0] d_data;
  logic        d_done;
  logic        mem_en;
  logic        mem_wr;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        mem_valid;
  logic        stray;

  int n_pass;
  int n_total;

  typedef struct {
    logic        side;
    logic [2:0]  idx;
    logic [15:0] data;
  } beat_t;

  beat_t sb[$];

  mem_arbiter dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_req        (i_req),
    .i_addr       (i_addr),
    .i_grant      (i_grant),
    .i_data_valid (i_data_valid),
    .i_word_idx   (i_word_idx),
    .i_data       (i_data),
    .i_done       (i_done),
    .d_req        (d_req),
    .d_wr         (d_wr),
    .d_addr       (d_addr),
    .d_wdata      (d_wdata),
    .d_grant      (d_grant),
    .d_data_valid (d_data_valid),
    .d_word_idx   (d_word_idx),
    .d_data       (d_data),
    .d_done       (d_done),
    .mem_en       (mem_en),
    .mem_wr       (mem_wr),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata),
    .mem_valid    (mem_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] pat(input logic [15:0] a);
    return a ^ 16'hA5C3;
  endfunction

  // Pipelined memory: read data appears MEM_LAT cycles after mem_en.
  logic [MEM_LAT-1:0] pv;
  logic [15:0]        pa [MEM_LAT];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pv <= '0;
      for (int i = 0; i < MEM_LAT; i++) pa[i] <= '0;
    end else begin
      pv    <= {pv[MEM_LAT-2:0], mem_en & ~mem_wr};
      pa[0] <= mem_addr;
      for (int i = 1; i < MEM_LAT; i++) pa[i] <= pa[i-1];
    end
  end

  assign mem_valid = pv[MEM_LAT-1] | stray;
  assign mem_rdata = pv[MEM_LAT-1] ? pat(pa[MEM_LAT-1])
                   : (stray ? 16'hDEAD : 16'h0000);

  task automatic push_line(input logic side, input logic [15:0] base);
    beat_t b;
    for (int j = 0; j < BURST_WORDS; j++) begin
      b.side = side;
      b.idx  = 3'(j);
      b.data = pat(base + 16'(2 * j));
      sb.push_back(b);
    end
  endtask

  // Scoreboard monitor: every returned word must match the next
  // expected beat in side, index and data.
  always @(negedge clk) begin
    if (rst_n && i_data_valid) begin
      n_total++;
      if (sb.size() == 0) begin
        $display("FAIL i_unexpected idx=%0d data=%h", i_word_idx, i_data);
      end else begin
        beat_t e;
        e = sb.pop_front();
        if ({1'b0, i_word_idx, i_data} !== {e.side, e.idx, e.data})
          $display("FAIL i_beat got idx=%0d data=%h want side=%0d idx=%0d data=%h",
                   i_word_idx, i_data, e.side, e.idx, e.data);
        else n_pass++;
      end
    end
    if (rst_n && d_data_valid) begin
      n_total++;
      if (sb.size() == 0) begin
        $display("FAIL d_unexpected idx=%0d data=%h", d_word_idx, d_data);
      end else begin
        beat_t e;
        e = sb.pop_front();
        if ({1'b1, d_word_idx, d_data} !== {e.side, e.idx, e.data})
          $display("FAIL d_beat got idx=%0d data=%h want side=%0d idx=%0d data=%h",
                   d_word_idx, d_data, e.side, e.idx, e.data);
        else n_pass++;
      end
    end
  end

  function automatic logic [77:0] all_out();
    return {i_grant, i_data_valid, i_word_idx, i_data, i_done,
            d_grant, d_data_valid, d_word_idx, d_data, d_done,
            mem_en, mem_wr, mem_addr, mem_wdata};
  endfunction

  task automatic sb_empty(input string name);
    n_total++;
    if (sb.size() != 0)
      $display("FAIL %s_sb_left got %0d want 0", name, sb.size());
    else n_pass++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    i_req = 0; i_addr = 0; d_req = 0; d_wr = 0;
    d_addr = 0; d_wdata = 0; stray = 0;
    repeat (3) @(negedge clk);
    n_total++;
    if (all_out() !== 78'd0)
      $display("FAIL reset_outs got %h want 0", all_out());
    else n_pass++;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_i_fill();
    i_req = 1; i_addr = 16'h1234;
    push_line(1'b0, 16'h1230);
    for (int k = 1; k <= 13; k++) begin
      @(negedge clk);
      if (k <= 8) begin
        n_total++;
        if ({i_grant, mem_en, mem_wr, mem_addr} !==
            {1'b1, 1'b1, 1'b0, 16'h1230 + 16'(2 * (k - 1))})
          $display("FAIL ifill_issue k=%0d got g=%b en=%b wr=%b a=%h want addr=%h",
                   k, i_grant, mem_en, mem_wr, mem_addr,
                   16'h1230 + 16'(2 * (k - 1)));
        else n_pass++;
      end
      if (k >= 5 && k <= 12) begin
        n_total++;
        if (i_data_valid !== 1'b1)
          $display("FAIL ifill_dv k=%0d got %b want 1", k, i_data_valid);
        else n_pass++;
      end
      n_total++;
      if ({d_grant, d_data_valid, d_done} !== 3'b000)
        $display("FAIL ifill_dside k=%0d got %b want 000",
                 k, {d_grant, d_data_valid, d_done});
      else n_pass++;
      if (k == 13) begin
        n_total++;
        if ({i_done, i_grant, mem_en} !== 3'b100)
          $display("FAIL ifill_done got done=%b g=%b en=%b want 1,0,0",
                   i_done, i_grant, mem_en);
        else n_pass++;
        i_req = 0;
      end
    end
    @(negedge clk);
    sb_empty("ifill");
  endtask

  task automatic test_priority();
    i_req = 1; i_addr = 16'h2222;
    d_req = 1; d_wr = 0; d_addr = 16'h0400;
    push_line(1'b1, 16'h0400);
    push_line(1'b0, 16'h2220);
    for (int k = 1; k <= 26; k++) begin
      @(negedge clk);
      if (k == 1) begin
        n_total++;
        if ({d_grant, i_grant, mem_addr} !== {2'b10, 16'h0400})
          $display("FAIL prio_first got dg=%b ig=%b a=%h want 1,0,0400",
                   d_grant, i_grant, mem_addr);
        else n_pass++;
      end
      if (k == 13) begin
        n_total++;
        if ({d_done, d_grant, i_grant} !== 3'b100)
          $display("FAIL prio_ddone got %b want 100",
                   {d_done, d_grant, i_grant});
        else n_pass++;
        d_req = 0;
      end
      if (k == 14) begin
        n_total++;
        if ({i_grant, mem_en, mem_addr} !== {2'b11, 16'h2220})
          $display("FAIL prio_igrant got g=%b en=%b a=%h want 1,1,2220",
                   i_grant, mem_en, mem_addr);
        else n_pass++;
      end
      if (k == 26) begin
        n_total++;
        if (i_done !== 1'b1)
          $display("FAIL prio_idone got %b want 1", i_done);
        else n_pass++;
        i_req = 0;
      end
    end
    @(negedge clk);
    sb_empty("prio");
  endtask

  task automatic test_write();
    d_req = 1; d_wr = 1; d_addr = 16'h0A02; d_wdata = 16'hBEEF;
    @(negedge clk);
    n_total++;
    if ({d_grant, mem_en, mem_wr, mem_addr, mem_wdata} !==
        {3'b111, 16'h0A02, 16'hBEEF})
      $display("FAIL wr_cycle got g=%b en=%b wr=%b a=%h wd=%h want 1,1,1,0a02,beef",
               d_grant, mem_en, mem_wr, mem_addr, mem_wdata);
    else n_pass++;
    @(negedge clk);
    n_total++;
    if ({d_done, d_grant, mem_en, mem_wdata} !== {3'b100, 16'h0})
      $display("FAIL wr_done got done=%b g=%b en=%b wd=%h want 1,0,0,0",
               d_done, d_grant, mem_en, mem_wdata);
    else n_pass++;
    d_req = 0; d_wr = 0;
    repeat (MEM_LAT + 1) begin
      @(negedge clk);
      n_total++;
      if ({i_data_valid, d_data_valid} !== 2'b00)
        $display("FAIL wr_nodv got %b want 00", {i_data_valid, d_data_valid});
      else n_pass++;
    end
  endtask

  task automatic test_mid_burst_d();
    i_req = 1; i_addr = 16'h3456;
    push_line(1'b0, 16'h3450);
    push_line(1'b1, 16'h0800);
    for (int k = 1; k <= 26; k++) begin
      @(negedge clk);
      if (k == 4) begin
        d_req = 1; d_wr = 0; d_addr = 16'h0808;
      end
      if (k == 5) begin
        n_total++;
        if ({i_grant, d_grant, mem_addr} !== {2'b10, 16'h3458})
          $display("FAIL mid_keep got ig=%b dg=%b a=%h want 1,0,3458",
                   i_grant, d_grant, mem_addr);
        else n_pass++;
      end
      if (k == 13) begin
        n_total++;
        if ({i_done, d_grant} !== 2'b10)
          $display("FAIL mid_idone got %b want 10", {i_done, d_grant});
        else n_pass++;
        i_req = 0;
      end
      if (k == 14) begin
        n_total++;
        if ({d_grant, mem_en, mem_addr} !== {2'b11, 16'h0800})
          $display("FAIL mid_dgrant got g=%b en=%b a=%h want 1,1,0800",
                   d_grant, mem_en, mem_addr);
        else n_pass++;
      end
      if (k == 26) begin
        n_total++;
        if (d_done !== 1'b1)
          $display("FAIL mid_ddone got %b want 1", d_done);
        else n_pass++;
        d_req = 0;
      end
    end
    @(negedge clk);
    sb_empty("mid");
    stray = 1;
    #1;
    n_total++;
    if ({i_data_valid, d_data_valid} !== 2'b00)
      $display("FAIL stray_dv got %b want 00", {i_data_valid, d_data_valid});
    else n_pass++;
    @(negedge clk);
    stray = 0;
  endtask

  task automatic test_reset_mid();
    i_req = 1; i_addr = 16'h5678;
    push_line(1'b0, 16'h5670);
    repeat (4) @(negedge clk);
    rst_n = 0;
    i_req = 0;
    sb.delete();
    #1;
    n_total++;
    if (all_out() !== 78'd0)
      $display("FAIL rstmid_outs got %h want 0", all_out());
    else n_pass++;
    @(negedge clk);
    rst_n = 1;
    i_req = 1; i_addr = 16'h6000;
    push_line(1'b0, 16'h6000);
    for (int k = 1; k <= 13; k++) begin
      @(negedge clk);
      if (k == 1) begin
        n_total++;
        if ({i_grant, mem_en, mem_addr} !== {2'b11, 16'h6000})
          $display("FAIL rstmid_restart got g=%b en=%b a=%h want 1,1,6000",
                   i_grant, mem_en, mem_addr);
        else n_pass++;
      end
      if (k == 13) begin
        n_total++;
        if (i_done !== 1'b1)
          $display("FAIL rstmid_done got %b want 1", i_done);
        else n_pass++;
        i_req = 0;
      end
    end
    @(negedge clk);
    sb_empty("rstmid");
  endtask

  task automatic test_back_to_back();
    d_req = 1; d_wr = 0; d_addr = 16'h1000;
    push_line(1'b1, 16'h1000);
    for (int k = 1; k <= 27; k++) begin
      @(negedge clk);
      if (k == 13) begin
        n_total++;
        if ({d_done, d_grant} !== 2'b10)
          $display("FAIL b2b_done1 got %b want 10", {d_done, d_grant});
        else n_pass++;
        d_addr = 16'h2000;
        push_line(1'b1, 16'h2000);
      end
      if (k == 14) begin
        n_total++;
        if ({d_grant, mem_en} !== 2'b00)
          $display("FAIL b2b_mask got g=%b en=%b want 0,0", d_grant, mem_en);
        else n_pass++;
      end
      if (k == 15) begin
        n_total++;
        if ({d_grant, mem_en, mem_addr} !== {2'b11, 16'h2000})
          $display("FAIL b2b_grant2 got g=%b en=%b a=%h want 1,1,2000",
                   d_grant, mem_en, mem_addr);
        else n_pass++;
      end
      if (k == 27) begin
        n_total++;
        if (d_done !== 1'b1)
          $display("FAIL b2b_done2 got %b want 1", d_done);
        else n_pass++;
        d_req = 0;
      end
    end
    @(negedge clk);
    sb_empty("b2b");
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    test_reset();
    test_i_fill();
    test_priority();
    test_write();
    test_mid_burst_d();
    test_reset_mid();
    test_back_to_back();
    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shared-memory arbiter and burst sequencer between the instruction-cache fill FSM and the data-cache path (fill FSM plus write-through stores), in front of the single pipelined main memory.
- Grants one requester at a time, with the data side at fixed priority.
- Generates the 8-word line-fill address sequence itself and steers returned words to the granted side with a word index.
- Signals completion with a one-cycle done pulse.

## Interface
- MEM_LAT, 4: cycles from a read's mem_en to its mem_valid; memory is pipelined and accepts one read per cycle.
- BURST_WORDS, 8: 16-bit words per cache line (16-byte line).
- clk  in  1  system clock
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low
- i_req  in  1  I-side fill request; level, held until i_done
- i_addr  in  16  I-side miss address; bits [3:0] are ignored (line-aligned internally)
- i_grant  out  1  I-side owns memory
- i_data_valid  out  1  i_data holds a returned fill word
- i_word_idx  out  3  index of that word within the line
- i_data  out  16  returned word
- i_done  out  1  one-cycle pulse: I burst complete
- d_req  in  1  D-side request; level, held until d_done
- d_wr  in  1  1 = single-word write, 0 = line fill
- d_addr  in  16  D-side address; line-aligned for fills, used as-is for writes
- d_wdata  in  16  write data
- d_grant, d_data_valid, d_word_idx, d_data, d_done  out  D-side equivalents of the I-side outputs
- mem_en  out  1  memory enable
- mem_wr  out  1  memory write
- mem_addr  out  16  memory address
- mem_wdata  out  16  memory write data
- mem_rdata  in  16  memory read data
- mem_valid  in  1  read data valid

## Operation
- States: IDLE, I_FILL, D_FILL, D_WRITE.
- IDLE arbitration:
  - d_req wins over i_req.
  - d_wr selects D_WRITE, otherwise D_FILL.
  - With no d_req, i_req selects I_FILL.
  - base = {addr[15:4], 4'h0} is latched, or the full d_addr/d_wdata for a write.
- Done-cycle masking: in a cycle where x_done is high, that requester's x_req is ignored for arbitration. The other side can still win in that cycle.
- FILL:
  - The issue counter runs 0..BURST_WORDS-1.
  - Each cycle it drives mem_en=1, mem_wr=0, mem_addr = base + 2*issue_cnt.
  - The return counter advances on each mem_valid.
  - mem_rdata is passed to x_data, with x_data_valid = mem_valid and x_word_idx = ret_cnt[2:0].
  - After the 8th mem_valid, the next cycle is IDLE with x_done=1.
- D_WRITE: for one cycle, mem_en=1, mem_wr=1, mem_addr=d_addr, mem_wdata=d_wdata. The next cycle is IDLE with d_done=1.
- x_grant is high in exactly the states owned by x. The other side's data_valid is never asserted.
- mem_valid outside a FILL state is ignored. It produces no data_valid to either side.
- Requests are not preempted. Dropping x_req mid-burst does not abort the burst; it runs to completion and done still pulses.
- mem_en is 0 in IDLE. mem_wdata is 0 except in D_WRITE.

## Timing
- All outputs are 0 in reset. Async assertion of rst_n forces IDLE and clears the counters, including mid-burst. Memory is reset by the same rst_n, so in-flight reads are discarded.
- Request sampled in IDLE at cycle t: grant and the first mem_en at t+1.
- Fill timing:
  - Reads are issued at t+1..t+8.
  - mem_valid arrives at t+1+MEM_LAT..t+8+MEM_LAT.
  - done pulses at t+9+MEM_LAT, with grant low in that cycle.
- Write: mem_en/mem_wr at t+1, d_done at t+2.
- Minimum gap between consecutive grants is 0 idle cycles beyond the done cycle. Arbitration occurs in the done cycle, and the next grant is in the following cycle.
- Counters are 4 bits wide, saturating at BURST_WORDS. Address adds wrap modulo 2^16; this is never reached because the base is aligned.

## Structure
- Package mem_arb_pkg holds:
  - the state enum
  - BURST_WORDS and MEM_LAT defaults
  - LINE_MASK = 16'hFFF0
  - the word-step constant 2
- Sub-module mem_burst_seq: the issue/return counters, address generation, and last-word detect. The parent holds arbitration, the FSM, and output steering.

## Test plan
- I fill only, i_addr=0x1234 at t:
  - mem_addr is 0x1230,0x1232,…,0x123E at t+1..t+8.
  - 8 i_data_valid with idx 0..7 at t+5..t+12.
  - i_done at t+13.
  - d_* outputs stay 0.
- i_req and d_req (fill, 0x0400) both rise in the same cycle:
  - D is granted first.
  - After d_done, i_grant starts the next cycle.
  - The I burst completes with the correct data.
- D write 0xBEEF to 0x0A02: one cycle of mem_en=1, mem_wr=1, addr 0x0A02, wdata 0xBEEF, then d_done. No data_valid on either side.
- d_req rises mid-I-burst: the I burst completes undisturbed, then D is granted with no lost cycle. A stray mem_valid in IDLE produces no data_valid.
- rst_n pulsed low after the 3rd issued read of a fill: all outputs 0 immediately. After release, a new i_req is serviced from word 0.
- Back-to-back D fills (req held through done, new address): the done cycle masks d_req, then the second fill is granted one cycle later.
